// File: rtl/touch_key_gen_if.sv
// Touch-key generator control bus: sequence request/parameters in,
// emulated key and status out.
interface touch_key_gen_if #(
   parameter int LEN_W = 16,
   parameter int CNT_W = 8
);
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] press_cnt;
   logic [LEN_W-1:0] press_len;
   logic [LEN_W-1:0] gap_len;
   logic             touch_key;
   logic             busy;
   logic             done;

   modport master (
      output start, abort, press_cnt, press_len, gap_len,
      input  touch_key, busy, done
   );

   modport slave (
      input  start, abort, press_cnt, press_len, gap_len,
      output touch_key, busy, done
   );
endinterface

// File: rtl/touch_key_gen.sv
// Emulates a touch key: press_cnt presses of press_len low cycles separated
// by gap_len high cycles, with abort, completion pulse and registered outputs.
module touch_key_gen #(
   parameter int LEN_W = 16,
   parameter int CNT_W = 8
) (
   input logic         sys_clk,
   input logic         sys_rst,
   touch_key_gen_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PRESS = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] rem_cnt;
   logic [LEN_W-1:0] len_cnt;
   logic [LEN_W-1:0] press_m1;
   logic [LEN_W-1:0] gap_m1;
   logic             touch_key_q;
   logic             busy_q;
   logic             done_q;
   logic             accept;

   // Zero-length requests behave as one cycle; result is the reload value.
   function automatic logic [LEN_W-1:0] len_m1(input logic [LEN_W-1:0] len);
      return (len == '0) ? '0 : len - LEN_W'(1);
   endfunction

   // A start landing on the done cycle is still treated as arriving while busy.
   assign accept = (state == IDLE) && bus.start && !bus.abort && !done_q &&
                   (bus.press_cnt != '0);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst && accept) begin
         press_m1 <= len_m1(bus.press_len);
         gap_m1   <= len_m1(bus.gap_len);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state       <= IDLE;
         rem_cnt     <= '0;
         len_cnt     <= '0;
         touch_key_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && !bus.abort && !done_q) begin
                  if (bus.press_cnt == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state       <= PRESS;
                     touch_key_q <= 1'b0;
                     busy_q      <= 1'b1;
                     rem_cnt     <= bus.press_cnt;
                     len_cnt     <= len_m1(bus.press_len);
                  end
               end
            end
            PRESS: begin
               if (bus.abort) begin
                  state       <= IDLE;
                  touch_key_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else if (len_cnt == '0) begin
                  if (rem_cnt != '0) rem_cnt <= rem_cnt - CNT_W'(1);
                  touch_key_q <= 1'b1;
                  if (rem_cnt <= CNT_W'(1)) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end else begin
                     state   <= GAP;
                     len_cnt <= gap_m1;
                  end
               end else begin
                  len_cnt <= len_cnt - LEN_W'(1);
               end
            end
            GAP: begin
               if (bus.abort) begin
                  state       <= IDLE;
                  touch_key_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else if (len_cnt == '0) begin
                  state       <= PRESS;
                  touch_key_q <= 1'b0;
                  len_cnt     <= press_m1;
               end else begin
                  len_cnt <= len_cnt - LEN_W'(1);
               end
            end
            default: begin
               state       <= IDLE;
               touch_key_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.touch_key = touch_key_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_touch_key_gen.sv
// Bench for touch_key_gen: per-cycle comparison against a queue-based model of
// the expected key waveform, plus literal waveform checks for known sequences.
module tb_touch_key_gen;
   localparam int LEN_W = 16;
   localparam int CNT_W = 8;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;

   touch_key_gen_if #(.LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

   touch_key_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Model: expected {touch_key, busy, done} after each edge. An accepted
   // sequence is expanded into its whole future waveform up front.
   logic [2:0] q[$];
   logic [2:0] exp_o = 3'b100;
   bit         model_on = 0;

   always @(posedge sys_clk) begin
      if (sys_rst) begin
         q.delete();
         exp_o    = 3'b100;
         model_on = 1;
      end else if (bus.abort) begin
         q.delete();
         exp_o = 3'b100;
      end else if (q.size() != 0) begin
         exp_o = q.pop_front();
      end else if (bus.start && !exp_o[0]) begin
         if (bus.press_cnt == 0) begin
            exp_o = 3'b101;
         end else begin
            int pl, gl;
            pl = (bus.press_len == 0) ? 1 : int'(bus.press_len);
            gl = (bus.gap_len == 0) ? 1 : int'(bus.gap_len);
            for (int p = 0; p < int'(bus.press_cnt); p++) begin
               for (int c = 0; c < pl; c++) q.push_back(3'b010);
               if (p < int'(bus.press_cnt) - 1)
                  for (int c = 0; c < gl; c++) q.push_back(3'b110);
            end
            q.push_back(3'b101);
            exp_o = q.pop_front();
         end
      end else begin
         exp_o = 3'b100;
      end
   end

   always @(negedge sys_clk) begin
      if (model_on) begin
         check("model_touch_key", 32'(bus.touch_key), 32'(exp_o[2]));
         check("model_busy",      32'(bus.busy),      32'(exp_o[1]));
         check("model_done",      32'(bus.done),      32'(exp_o[0]));
      end
   end

   task automatic start_seq(input int cnt, input int pl, input int gl);
      @(negedge sys_clk);
      bus.start     = 1'b1;
      bus.press_cnt = CNT_W'(cnt);
      bus.press_len = LEN_W'(pl);
      bus.gap_len   = LEN_W'(gl);
      @(negedge sys_clk);
      bus.start = 1'b0;
   endtask

   task automatic record(input int n, output logic [31:0] tk, output logic [31:0] bz,
                         output logic [31:0] dn);
      tk = '0; bz = '0; dn = '0;
      for (int i = 0; i < n; i++) begin
         if (i != 0) @(negedge sys_clk);
         tk = {tk[30:0], bus.touch_key};
         bz = {bz[30:0], bus.busy};
         dn = {dn[30:0], bus.done};
      end
   endtask

   task automatic wait_done(input int limit);
      int n;
      n = 0;
      while (!bus.done && n < limit) begin
         @(negedge sys_clk);
         n++;
      end
      check("done_seen", 32'(bus.done), 32'd1);
   endtask

   initial begin
      logic [31:0] tk, bz, dn;
      int i;
      bus.start = 1'b0; bus.abort = 1'b0;
      bus.press_cnt = '0; bus.press_len = '0; bus.gap_len = '0;

      repeat (3) @(negedge sys_clk);
      check("reset_touch_key", 32'(bus.touch_key), 32'd1);
      check("reset_busy",      32'(bus.busy),      32'd0);
      check("reset_done",      32'(bus.done),      32'd0);
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);

      // Single press
      start_seq(1, 4, 9);
      record(6, tk, bz, dn);
      check("single_tk",   tk, 32'b000011);
      check("single_busy", bz, 32'b111100);
      check("single_done", dn, 32'b000010);
      repeat (3) @(negedge sys_clk);

      // Three presses with gaps
      start_seq(3, 2, 3);
      record(13, tk, bz, dn);
      check("multi_tk",   tk, 32'b0011100111001);
      check("multi_busy", bz, 32'b1111111111110);
      check("multi_done", dn, 32'b0000000000001);
      repeat (3) @(negedge sys_clk);

      // Zero presses
      start_seq(0, 5, 5);
      record(2, tk, bz, dn);
      check("zero_cnt_tk",   tk, 32'b11);
      check("zero_cnt_busy", bz, 32'b00);
      check("zero_cnt_done", dn, 32'b10);
      repeat (3) @(negedge sys_clk);

      // Zero lengths behave as one cycle
      start_seq(2, 0, 0);
      record(4, tk, bz, dn);
      check("zero_len_tk",   tk, 32'b0101);
      check("zero_len_busy", bz, 32'b1110);
      check("zero_len_done", dn, 32'b0001);
      repeat (3) @(negedge sys_clk);

      // Abort in the 4th cycle of the second press
      start_seq(5, 10, 3);
      repeat (16) @(negedge sys_clk);
      check("abort_pre_tk",   32'(bus.touch_key), 32'd0);
      check("abort_pre_busy", 32'(bus.busy),      32'd1);
      bus.abort = 1'b1;
      @(negedge sys_clk);
      bus.abort = 1'b0;
      check("abort_tk",   32'(bus.touch_key), 32'd1);
      check("abort_busy", 32'(bus.busy),      32'd0);
      check("abort_done", 32'(bus.done),      32'd0);
      repeat (5) @(negedge sys_clk);
      start_seq(2, 3, 2);
      wait_done(100);
      repeat (3) @(negedge sys_clk);

      // Restart and input changes mid-sequence are ignored
      start_seq(2, 3, 2);
      i = 1;
      while (!bus.done && i < 50) begin
         if (i == 1) begin
            bus.start = 1'b1; bus.press_cnt = 8'd4;
            bus.press_len = 16'd7; bus.gap_len = 16'd9;
         end
         if (i == 2) bus.start = 1'b0;
         @(negedge sys_clk);
         i++;
      end
      check("latched_done_cycle", 32'(i), 32'd9);

      // Start during done is ignored; start right after done is accepted
      bus.start = 1'b1; bus.press_cnt = 8'd1; bus.press_len = 16'd2; bus.gap_len = 16'd1;
      @(negedge sys_clk);
      check("start_on_done_busy", 32'(bus.busy), 32'd0);
      @(negedge sys_clk);
      bus.start = 1'b0;
      check("b2b_busy", 32'(bus.busy),      32'd1);
      check("b2b_tk",   32'(bus.touch_key), 32'd0);
      wait_done(20);
      repeat (3) @(negedge sys_clk);

      // Reset mid-press, then start in the first cycle after reset
      start_seq(3, 8, 2);
      repeat (3) @(negedge sys_clk);
      check("rst_pre_tk", 32'(bus.touch_key), 32'd0);
      sys_rst = 1'b1; bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge sys_clk);
      check("rst_tk",   32'(bus.touch_key), 32'd1);
      check("rst_busy", 32'(bus.busy),      32'd0);
      check("rst_done", 32'(bus.done),      32'd0);
      repeat (2) @(negedge sys_clk);
      check("rst_hold_tk", 32'(bus.touch_key), 32'd1);
      sys_rst = 1'b0; bus.abort = 1'b0; bus.start = 1'b1;
      bus.press_cnt = 8'd1; bus.press_len = 16'd1;
      @(negedge sys_clk);
      bus.start = 1'b0;
      check("post_rst_busy", 32'(bus.busy),      32'd1);
      check("post_rst_tk",   32'(bus.touch_key), 32'd0);
      @(negedge sys_clk);
      check("post_rst_done", 32'(bus.done), 32'd1);
      repeat (3) @(negedge sys_clk);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge sys_clk);
         sys_rst       = ($urandom_range(0, 499) == 0);
         bus.start     = ($urandom_range(0, 3) == 0);
         bus.abort     = ($urandom_range(0, 59) == 0);
         bus.press_cnt = CNT_W'($urandom_range(0, 4));
         bus.press_len = LEN_W'($urandom_range(0, 5));
         bus.gap_len   = LEN_W'($urandom_range(0, 5));
      end
      @(negedge sys_clk);
      sys_rst = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
      repeat (80) @(negedge sys_clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
